control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_control_fsm.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multi-cycle control unit for an RV32I integer subset (OP-IMM, OP, LUI).
// Runs FETCH -> DECODE -> EXECUTE -> WRITEBACK per instruction and parks in TRAP on an illegal encoding.
module control_fsm #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  output logic [4:0]        rf_waddr,
  output logic              rf_we,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic [XLEN-1:0]   imm,
  output logic              pc_inc,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_TRAP
  } state_e;

  state_e           state_q;
  logic [31:0]      ir_q;
  logic             ready_q;
  logic [4:0]       raddr1_q;
  logic [4:0]       raddr2_q;
  logic [4:0]       waddr_q;
  logic             we_q;
  logic [3:0]       op_q;
  logic             src_imm_q;
  logic [XLEN-1:0]  imm_q;
  logic             pc_inc_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             dec_legal;
  logic [3:0]       dec_op;
  logic             dec_src_imm;
  logic [XLEN-1:0]  dec_imm;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // Instruction decode of the held IR; only consumed while in DECODE.
  always_comb begin
    dec_legal   = 1'b0;
    dec_op      = ALU_ADD;
    dec_src_imm = 1'b0;
    dec_imm     = '0;
    case (opcode)
      OPC_OP_IMM: begin
        dec_src_imm = 1'b1;
        dec_imm     = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD;  end
          3'b010: begin dec_legal = 1'b1; dec_op = ALU_SLT;  end
          3'b011: begin dec_legal = 1'b1; dec_op = ALU_SLTU; end
          3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR;  end
          3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;   end
          3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND;  end
          3'b001: begin
            dec_legal = (funct7 == F7_BASE);
            dec_op    = ALU_SLL;
            dec_imm   = XLEN'(ir_q[24:20]);
          end
          default: begin
            dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            dec_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_imm   = XLEN'(ir_q[24:20]);
          end
        endcase
      end
      OPC_OP: begin
        case (funct7)
          F7_BASE: begin
            dec_legal = 1'b1;
            case (funct3)
              3'b000:  dec_op = ALU_ADD;
              3'b001:  dec_op = ALU_SLL;
              3'b010:  dec_op = ALU_SLT;
              3'b011:  dec_op = ALU_SLTU;
              3'b100:  dec_op = ALU_XOR;
              3'b101:  dec_op = ALU_SRL;
              3'b110:  dec_op = ALU_OR;
              default: dec_op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (funct3 == 3'b000) begin
              dec_legal = 1'b1;
              dec_op    = ALU_SUB;
            end else if (funct3 == 3'b101) begin
              dec_legal = 1'b1;
              dec_op    = ALU_SRA;
            end
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_legal   = 1'b1;
        dec_op      = ALU_PASSB;
        dec_src_imm = 1'b1;
        dec_imm     = XLEN'($signed({ir_q[31:12], 12'b0}));
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Outputs are registered on entry to the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      ready_q   <= 1'b1;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      op_q      <= '0;
      src_imm_q <= 1'b0;
      imm_q     <= '0;
      pc_inc_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      we_q     <= 1'b0;
      pc_inc_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (instr_valid) begin
            ir_q    <= instr;
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          raddr1_q  <= ir_q[19:15];
          raddr2_q  <= ir_q[24:20];
          waddr_q   <= ir_q[11:7];
          op_q      <= dec_op;
          src_imm_q <= dec_src_imm;
          imm_q     <= dec_imm;
          if (dec_legal) begin
            state_q <= S_EXECUTE;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= S_TRAP;
          end
        end
        S_EXECUTE: begin
          we_q      <= (ir_q[11:7] != 5'd0);
          pc_inc_q  <= 1'b1;
          retired_q <= retired_q + CNT_W'(1);
          state_q   <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          ready_q <= 1'b1;
          state_q <= S_FETCH;
        end
        S_TRAP: state_q <= S_TRAP;
        default: begin
          ready_q <= 1'b1;
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign rf_raddr1   = raddr1_q;
  assign rf_raddr2   = raddr2_q;
  assign rf_waddr    = waddr_q;
  assign rf_we       = we_q;
  assign alu_op      = op_q;
  assign alu_src_imm = src_imm_q;
  assign imm         = imm_q;
  assign pc_inc      = pc_inc_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed and random instruction streams against a table-driven decode model.
// A second instance with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;

  logic        instr_ready, rf_we, alu_src_imm, pc_inc, illegal;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [3:0]  alu_op;
  logic [31:0] imm;
  logic [31:0] retired;

  logic        r4_ready, r4_we, r4_src, r4_pc_inc, r4_illegal;
  logic [4:0]  r4_ra1, r4_ra2, r4_wa;
  logic [3:0]  r4_op;
  logic [31:0] r4_imm;
  logic [3:0]  r4_retired;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_retired;
  logic [31:0] last_w;
  logic [3:0]  exp_op;
  logic        exp_src;
  logic [31:0] exp_imm;

  // ALU op per funct3, one nibble each (f3=0 in the low nibble).
  localparam logic [31:0] OPTAB = 32'h98654320;

  always #5 clk = ~clk;

  control_fsm #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_waddr(rf_waddr), .rf_we(rf_we), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .imm(imm), .pc_inc(pc_inc), .illegal(illegal), .retired(retired)
  );

  control_fsm #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(r4_ready), .rf_raddr1(r4_ra1), .rf_raddr2(r4_ra2),
    .rf_waddr(r4_wa), .rf_we(r4_we), .alu_op(r4_op), .alu_src_imm(r4_src),
    .imm(r4_imm), .pc_inc(r4_pc_inc), .illegal(r4_illegal), .retired(r4_retired)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void ref_decode(input logic [31:0] w, output logic legal,
                                     output logic [3:0] op, output logic src,
                                     output logic [31:0] im);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       shift;
    f3    = w[14:12];
    f7    = w[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    legal = 1'b0;
    op    = OPTAB[f3*4 +: 4] + 4'(f7 == 7'h20);
    src   = 1'b0;
    im    = 32'd0;
    if (w[6:0] == 7'h13) begin
      src = 1'b1;
      if (!shift) begin
        legal = 1'b1;
        op    = OPTAB[f3*4 +: 4];
        im    = {{20{w[31]}}, w[31:20]};
      end else begin
        legal = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        im    = {27'd0, w[24:20]};
      end
    end else if (w[6:0] == 7'h33) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (w[6:0] == 7'h37) begin
      legal = 1'b1;
      op    = 4'd10;
      src   = 1'b1;
      im    = {w[31:12], 12'd0};
    end
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    logic        l, s;
    logic [3:0]  o;
    logic [31:0] i;
    for (int k = 0; k < 1000; k++) begin
      w = $urandom;
      case ($urandom_range(2))
        0:       w[6:0] = 7'h13;
        1:       w[6:0] = 7'h33;
        default: w[6:0] = 7'h37;
      endcase
      if ($urandom_range(1) == 1) w[31:25] = ($urandom_range(1) == 1) ? 7'h20 : 7'h00;
      ref_decode(w, l, o, s, i);
      if (l) return w;
    end
    return 32'h00500093;
  endfunction

  // One full transaction from FETCH; legal words retire, illegal ones are watched in TRAP.
  task automatic do_instr(input logic [31:0] w);
    logic        legal, src;
    logic [3:0]  op;
    logic [31:0] im;
    ref_decode(w, legal, op, src, im);
    vectors++;
    if ({instr_ready, r4_ready} !== 2'b11) begin
      miscompares++; $display("FAIL accept_ready w=%h got %b exp 11", w, {instr_ready, r4_ready});
    end
    instr = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; instr = $urandom;
    vectors++;
    if ({instr_ready, rf_we, pc_inc, illegal} !== 4'b0000) begin
      miscompares++; $display("FAIL decode_cycle w=%h got %b exp 0000", w, {instr_ready, rf_we, pc_inc, illegal});
    end
    tick();
    vectors++;
    if ({rf_raddr1, rf_raddr2, rf_waddr} !== {w[19:15], w[24:20], w[11:7]}) begin
      miscompares++; $display("FAIL reg_fields w=%h got %h exp %h", w, {rf_raddr1, rf_raddr2, rf_waddr}, {w[19:15], w[24:20], w[11:7]});
    end
    vectors++;
    if (illegal !== !legal) begin
      miscompares++; $display("FAIL illegal_flag w=%h got %b exp %b", w, illegal, !legal);
    end
    if (legal) begin
      exp_op = op; exp_src = src; exp_imm = im; last_w = w;
      vectors++;
      if ({alu_op, alu_src_imm, imm} !== {op, src, im}) begin
        miscompares++; $display("FAIL decode w=%h got op=%0d src=%b imm=%h exp op=%0d src=%b imm=%h", w, alu_op, alu_src_imm, imm, op, src, im);
      end
      vectors++;
      if ({rf_we, pc_inc, instr_ready} !== 3'b000) begin
        miscompares++; $display("FAIL execute_cycle w=%h got %b exp 000", w, {rf_we, pc_inc, instr_ready});
      end
      tick();
      exp_retired = exp_retired + 32'd1;
      vectors++;
      if ({rf_we, pc_inc} !== {(w[11:7] != 5'd0), 1'b1}) begin
        miscompares++; $display("FAIL writeback w=%h got we=%b pc_inc=%b exp we=%b pc_inc=1", w, rf_we, pc_inc, (w[11:7] != 5'd0));
      end
      vectors++;
      if (retired !== exp_retired || r4_retired !== exp_retired[3:0]) begin
        miscompares++; $display("FAIL retired w=%h got %0d/%0d exp %0d/%0d", w, retired, r4_retired, exp_retired, exp_retired[3:0]);
      end
      tick();
      vectors++;
      if ({rf_we, pc_inc, instr_ready, r4_ready} !== 4'b0011) begin
        miscompares++; $display("FAIL back_to_fetch w=%h got %b exp 0011", w, {rf_we, pc_inc, instr_ready, r4_ready});
      end
    end else begin
      for (int c = 0; c < 20; c++) begin
        tick();
        vectors++;
        if ({illegal, instr_ready, rf_we, pc_inc} !== 4'b1000 || retired !== exp_retired) begin
          miscompares++; $display("FAIL trap_hold w=%h cyc=%0d got %b ret=%0d exp 1000 ret=%0d", w, c, {illegal, instr_ready, rf_we, pc_inc}, retired, exp_retired);
        end
      end
    end
  endtask

  task automatic clear_model();
    exp_retired = 32'd0; last_w = 32'd0; exp_op = 4'd0; exp_src = 1'b0; exp_imm = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0;
    clear_model();
    tick(); tick();
    vectors++;
    if ({instr_ready, rf_we, pc_inc, illegal, alu_src_imm} !== 5'b10000 || retired !== 32'd0 || r4_retired !== 4'd0) begin
      miscompares++; $display("FAIL reset_flags got %b ret=%0d exp 10000 ret=0", {instr_ready, rf_we, pc_inc, illegal, alu_src_imm}, retired);
    end
    vectors++;
    if ({rf_raddr1, rf_raddr2, rf_waddr, alu_op, imm} !== 51'd0) begin
      miscompares++; $display("FAIL reset_fields got %h exp 0", {rf_raddr1, rf_raddr2, rf_waddr, alu_op, imm});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    do_instr(32'h00500093);
    vectors++;
    if ({alu_op, alu_src_imm, imm, rf_waddr, rf_raddr1} !== {4'd0, 1'b1, 32'd5, 5'd1, 5'd0}) begin
      miscompares++; $display("FAIL addi_const got op=%0d imm=%h rd=%0d", alu_op, imm, rf_waddr);
    end
    do_instr(32'hFFF00113);
    vectors++;
    if (imm !== 32'hFFFFFFFF) begin
      miscompares++; $display("FAIL addi_neg got %h exp ffffffff", imm);
    end
    do_instr(32'h40325213);
    vectors++;
    if ({alu_op, imm} !== {4'd7, 32'd3}) begin
      miscompares++; $display("FAIL srai_const got op=%0d imm=%h exp op=7 imm=3", alu_op, imm);
    end
    do_instr(32'h402081B3);
    vectors++;
    if ({alu_op, alu_src_imm, rf_raddr1, rf_raddr2, rf_waddr} !== {4'd1, 1'b0, 5'd1, 5'd2, 5'd3}) begin
      miscompares++; $display("FAIL sub_const got op=%0d src=%b", alu_op, alu_src_imm);
    end
    do_instr(32'h123452B7);
    vectors++;
    if ({alu_op, imm} !== {4'd10, 32'h12345000}) begin
      miscompares++; $display("FAIL lui_const got op=%0d imm=%h exp op=10 imm=12345000", alu_op, imm);
    end
    do_instr(32'h00100013);
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      instr = $urandom;
      tick();
      vectors++;
      if ({instr_ready, rf_we, pc_inc, illegal} !== 4'b1000 || retired !== exp_retired ||
          {rf_raddr1, rf_raddr2, rf_waddr} !== {last_w[19:15], last_w[24:20], last_w[11:7]} ||
          {alu_op, alu_src_imm, imm} !== {exp_op, exp_src, exp_imm}) begin
        miscompares++; $display("FAIL idle cyc=%0d got flags=%b ret=%0d op=%0d imm=%h", c, {instr_ready, rf_we, pc_inc, illegal}, retired, alu_op, imm);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) do_instr(rand_legal());
  endtask

  task automatic test_reset_midflight();
    instr = 32'h00500093; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    clear_model();
    vectors++;
    if ({instr_ready, rf_we, pc_inc, illegal} !== 4'b1000 || retired !== 32'd0 || r4_retired !== 4'd0 ||
        {rf_raddr1, rf_raddr2, rf_waddr, alu_op, imm} !== 51'd0) begin
      miscompares++; $display("FAIL async_reset got %b ret=%0d exp 1000 ret=0", {instr_ready, rf_we, pc_inc, illegal}, retired);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({rf_we, pc_inc} !== 2'b00 || retired !== 32'd0) begin
        miscompares++; $display("FAIL reset_hold cyc=%0d got we=%b pc=%b ret=%0d", c, rf_we, pc_inc, retired);
      end
    end
    rst_n = 1'b1;
    do_instr(rand_legal());
  endtask

  task automatic test_trap();
    logic [31:0] bad [2];
    bad[0] = 32'h00000000;
    bad[1] = 32'h021081B3;
    for (int b = 0; b < 2; b++) begin
      do_instr(bad[b]);
      #1 rst_n = 1'b0;
      #1;
      clear_model();
      vectors++;
      if ({illegal, instr_ready} !== 2'b01 || retired !== 32'd0) begin
        miscompares++; $display("FAIL trap_exit w=%h got %b exp 01", bad[b], {illegal, instr_ready});
      end
      tick();
      rst_n = 1'b1;
    end
    do_instr(32'h00500093);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle();
    test_random();
    test_reset_midflight();
    test_trap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
